// File: rtl/fir_decim_out_buffer.sv
// Decimates the FIR output stream by 2**LOG2_D and buffers the results in a FWFT FIFO with sticky overflow.
// Optional: define DECIM_AVG_EN to replace last-sample pick with boxcar averaging over each window.
module fir_decim_out_buffer #(
  parameter int N      = 16,
  parameter int LOG2_D = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [N-1:0]       in_data,
  input  logic                      in_valid,
  output logic signed [N-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count,
  input  logic                      clear_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int PH_W = (LOG2_D > 0) ? LOG2_D : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'((2 ** LOG2_D) - 1);

  logic [PH_W-1:0]          phase_q, phase_d;
  logic signed [N-1:0]      mem_q [DEPTH];
  logic signed [N-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]        count_q, count_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [N-1:0]      out_data_q, out_data_d;
  logic                     overflow_q, overflow_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic signed [N-1:0]      sample_s;
  logic                     produce_s, pop_s, push_s, drop_s, full_s;

  // Phase counter: only valid samples advance the decimation window.
  always_comb begin
    produce_s = in_valid && (phase_q == LAST_PH);
    if (!in_valid) begin
      phase_d = phase_q;
    end else if (phase_q == LAST_PH) begin
      phase_d = {PH_W{1'b0}};
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
  end

`ifdef DECIM_AVG_EN
  localparam int ACC_W = N + LOG2_D;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_s, in_ext_s;

  // Boxcar sum: phase 0 restarts the window; the produced value includes the current sample.
  always_comb begin
    in_ext_s = ACC_W'(in_data);
    if (phase_q == {PH_W{1'b0}}) begin
      sum_s = in_ext_s;
    end else begin
      sum_s = acc_q + in_ext_s;
    end
    if (in_valid) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
    sample_s = N'(sum_s >>> LOG2_D);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  // Pick mode: the last sample of each window passes through unchanged.
  always_comb begin
    sample_s = in_data;
  end
`endif

  // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    full_s   = (count_q == CNT_FW'(DEPTH));
    pop_s    = out_valid_q && out_ready;
    push_s   = produce_s && (!full_s || pop_s);
    drop_s   = produce_s && full_s && !pop_s;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = sample_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != {CNT_FW{1'b0}});
    if (out_valid_d) begin
      out_data_d = mem_d[rd_ptr_d];
    end else begin
      out_data_d = {N{1'b0}};
    end
  end

  // Overflow flag and saturating drop counter; a drop outranks a coincident clear.
  always_comb begin
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clear_ovf) begin
        drop_cnt_d = CNT_W'(1);
      end else if (&drop_cnt_q) begin
        drop_cnt_d = drop_cnt_q;
      end else begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = {CNT_W{1'b0}};
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers; reset discards FIFO contents and any partial window.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= {PH_W{1'b0}};
      mem_q       <= '{default: {N{1'b0}}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_FW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {N{1'b0}};
      overflow_q  <= 1'b0;
      drop_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      phase_q     <= phase_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule
